// File: rtl/program_sequencer.sv
// Switch-programmed sequencer: instructions are keyed in field by field, stored,
// then executed on a small register file with an ALU and a conditional jump.
module program_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 8,
  parameter  int DEPTH = 16,
  localparam int RW    = $clog2(NREGS),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] inputs,
  input  logic             setButton,
  input  logic             runButton,
  input  logic [RW-1:0]    regSel,
  output logic [WIDTH-1:0] regValue,
  output logic [2:0]       state,
  output logic [PW-1:0]    pc,
  output logic [PW:0]      count,
  output logic             full,
  output logic             carry,
  output logic             done,
  output logic             aborted
);

  localparam int IW = 4 + 2 * RW + WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LDI  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_JNZ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  typedef enum logic [2:0] {
    S_ENTER_OP  = 3'd0,
    S_ENTER_RD  = 3'd1,
    S_ENTER_RS  = 3'd2,
    S_ENTER_IMM = 3'd3,
    S_FETCH     = 3'd4,
    S_EXEC      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // Returns {carry, result}; bit WIDTH is the carry (ADD/ADDI) or borrow (SUB).
  function automatic logic [WIDTH:0] alu(input logic [3:0]       op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] imm,
                                         input logic             cin);
    logic [WIDTH:0] r;
    r = {cin, a};
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {cin, a & b};
      OP_OR:   r = {cin, a | b};
      OP_XOR:  r = {cin, a ^ b};
      OP_LDI:  r = {cin, imm};
      OP_ADDI: r = {1'b0, a} + {1'b0, imm};
      OP_MOV:  r = {cin, b};
      default: r = {cin, a};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             set_s1_q, set_s2_q, set_prev_q;
  logic             run_s1_q, run_s2_q, run_prev_q;
  logic             set_press, run_press;
  logic [3:0]       op_q;
  logic [RW-1:0]    rd_q, rs_q;
  logic [IW-1:0]    ir_q;
  logic [PW-1:0]    pc_q;
  logic [PW:0]      count_q;
  logic             carry_q, aborted_q;
  logic [WIDTH-1:0] regval_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [IW-1:0]    mem_q  [DEPTH];
  logic             full_w;

  logic [3:0]       ex_op;
  logic [RW-1:0]    ex_rd, ex_rs;
  logic [WIDTH-1:0] ex_imm, rd_val, rs_val;
  logic [WIDTH:0]   alu_res;
  logic             ex_wr;
  logic [PW:0]      npc_ext;
  logic             exec_end;

  // Button conditioning: two-flop synchroniser plus falling-edge detect.
  always_ff @(posedge clock) begin
    if (reset) begin
      set_s1_q   <= 1'b1;
      set_s2_q   <= 1'b1;
      set_prev_q <= 1'b1;
      run_s1_q   <= 1'b1;
      run_s2_q   <= 1'b1;
      run_prev_q <= 1'b1;
    end else begin
      set_s1_q   <= setButton;
      set_s2_q   <= set_s1_q;
      set_prev_q <= set_s2_q;
      run_s1_q   <= runButton;
      run_s2_q   <= run_s1_q;
      run_prev_q <= run_s2_q;
    end
  end

  assign set_press = set_prev_q & ~set_s2_q;
  assign run_press = run_prev_q & ~run_s2_q;
  assign full_w    = (count_q == (PW+1)'(DEPTH));

  assign {ex_op, ex_rd, ex_rs, ex_imm} = ir_q;
  assign rd_val  = regs_q[ex_rd];
  assign rs_val  = regs_q[ex_rs];
  assign alu_res = alu(ex_op, rd_val, rs_val, ex_imm, carry_q);
  assign ex_wr   = ~ex_op[3];

  always_comb begin
    npc_ext = {1'b0, pc_q} + (PW+1)'(1);
    if (ex_op == OP_JNZ && rd_val != '0) begin
      npc_ext = {1'b0, ex_imm[PW-1:0]};
    end else if (ex_op == OP_HALT) begin
      npc_ext = {1'b0, pc_q};
    end
    exec_end = (ex_op == OP_HALT) || (npc_ext >= count_q);
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_ENTER_OP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ENTER_OP: begin
        if (set_press)                        state_d = S_ENTER_RD;
        else if (run_press && count_q != '0)  state_d = S_FETCH;
      end
      S_ENTER_RD:  if (set_press) state_d = S_ENTER_RS;
      S_ENTER_RS:  if (set_press) state_d = S_ENTER_IMM;
      S_ENTER_IMM: if (set_press) state_d = S_ENTER_OP;
      S_FETCH:     state_d = set_press ? S_DONE : S_EXEC;
      S_EXEC:      state_d = (set_press || exec_end) ? S_DONE : S_FETCH;
      S_DONE: begin
        if (set_press)      state_d = S_ENTER_OP;
        else if (run_press) state_d = S_FETCH;
      end
      default: state_d = S_ENTER_OP;
    endcase
  end

  always_comb begin
    state    = state_q;
    done     = (state_q == S_DONE);
    pc       = pc_q;
    count    = count_q;
    full     = full_w;
    carry    = carry_q;
    aborted  = aborted_q;
    regValue = regval_q;
  end

  // An instruction in EXEC completes even when a set press aborts the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      ir_q      <= '0;
      pc_q      <= '0;
      count_q   <= '0;
      carry_q   <= 1'b0;
      aborted_q <= 1'b0;
      regval_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regval_q <= regs_q[regSel];
      case (state_q)
        S_ENTER_OP: begin
          if (set_press)                       op_q <= inputs[3:0];
          else if (run_press && count_q != '0) pc_q <= '0;
        end
        S_ENTER_RD: if (set_press) rd_q <= inputs[RW-1:0];
        S_ENTER_RS: if (set_press) rs_q <= inputs[RW-1:0];
        S_ENTER_IMM: begin
          if (set_press && !full_w) count_q <= count_q + (PW+1)'(1);
        end
        S_FETCH: begin
          ir_q <= mem_q[pc_q];
          if (set_press) aborted_q <= 1'b1;
        end
        S_EXEC: begin
          if (ex_wr) begin
            regs_q[ex_rd] <= alu_res[WIDTH-1:0];
            carry_q       <= alu_res[WIDTH];
          end
          pc_q <= npc_ext[PW-1:0];
          if (set_press) aborted_q <= 1'b1;
        end
        S_DONE: begin
          if (set_press) begin
            count_q   <= '0;
            aborted_q <= 1'b0;
          end else if (run_press) begin
            pc_q      <= '0;
            aborted_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction memory is deliberately unreset; clearing count hides old entries.
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_ENTER_IMM && set_press && !full_w) begin
      mem_q[count_q[PW-1:0]] <= {op_q, rd_q, rs_q, inputs};
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: expectations are queued as programs are
// keyed in and run, then drained against the DUT outputs.
module tb_program_sequencer;

  localparam int K_REG = 0, K_PC = 1, K_CARRY = 2, K_ABORT = 3, K_STATE = 4,
                 K_COUNT = 5, K_FULL = 6, K_DONE = 7, K_CYC = 8;

  typedef struct {
    string tag;
    int    kind;
    int    idx;
    int    val;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] inputs;
  logic       setButton, runButton;
  logic [2:0] regSel;
  logic [7:0] regValue;
  logic [2:0] state;
  logic [3:0] pc;
  logic [4:0] count;
  logic       full, carry, done, aborted;

  int   n_checks = 0;
  int   n_errors = 0;
  int   run_cyc  = 0;
  exp_t sb[$];

  program_sequencer #(.WIDTH(8), .NREGS(8), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .inputs(inputs),
    .setButton(setButton), .runButton(runButton), .regSel(regSel),
    .regValue(regValue), .state(state), .pc(pc), .count(count),
    .full(full), .carry(carry), .done(done), .aborted(aborted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int idx, input int val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input int idx, output int v);
    case (kind)
      K_REG: begin
        regSel = idx[2:0];
        @(negedge clock);
        v = int'(regValue);
      end
      K_PC:    v = int'(pc);
      K_CARRY: v = int'(carry);
      K_ABORT: v = int'(aborted);
      K_STATE: v = int'(state);
      K_COUNT: v = int'(count);
      K_FULL:  v = int'(full);
      K_DONE:  v = int'(done);
      K_CYC:   v = run_cyc;
      default: v = -1;
    endcase
  endtask

  task automatic drain();
    exp_t e;
    int   v;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      observe(e.kind, e.idx, v);
      chk(e.tag, v, e.val);
    end
  endtask

  task automatic press(input bit is_set);
    @(negedge clock);
    if (is_set) setButton = 1'b0;
    else        runButton = 1'b0;
    @(negedge clock);
    setButton = 1'b1;
    runButton = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic press_both();
    @(negedge clock);
    setButton = 1'b0;
    runButton = 1'b0;
    @(negedge clock);
    setButton = 1'b1;
    runButton = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic enter(input int op, input int rd, input int rs, input int imm);
    inputs = 8'(op);  press(1'b1);
    inputs = 8'(rd);  press(1'b1);
    inputs = 8'(rs);  press(1'b1);
    inputs = 8'(imm); press(1'b1);
  endtask

  // Counts cycles from the first FETCH until done rises.
  task automatic run_prog(input bit wait_done);
    bit found;
    int n;
    found = 1'b0;
    @(negedge clock);
    runButton = 1'b0;
    @(negedge clock);
    runButton = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (state == 3'd4) found = 1'b1;
    end
    if (!found) begin
      chk("run_start_timeout", 0, 1);
    end else if (wait_done) begin
      n = 0;
      while (!done && n < 3000) begin
        @(negedge clock);
        n++;
      end
      if (!done) chk("run_done_timeout", 0, 1);
      run_cyc = n;
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; inputs = '0; setButton = 1'b1; runButton = 1'b1; regSel = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    push("rst_state", K_STATE, 0, 0);  push("rst_pc", K_PC, 0, 0);
    push("rst_count", K_COUNT, 0, 0);  push("rst_full", K_FULL, 0, 0);
    push("rst_carry", K_CARRY, 0, 0);  push("rst_done", K_DONE, 0, 0);
    push("rst_abort", K_ABORT, 0, 0);  push("rst_r0", K_REG, 0, 0);
    drain();

    // LDI r1,5; LDI r2,3; ADD r1,r2; HALT
    enter(5, 1, 0, 5); enter(5, 2, 0, 3); enter(0, 1, 2, 0); enter(9, 0, 0, 0);
    push("p1_count", K_COUNT, 0, 4);
    drain();
    run_prog(1'b1);
    push("p1_cycles", K_CYC, 0, 8);   push("p1_state", K_STATE, 0, 6);
    push("p1_done", K_DONE, 0, 1);    push("p1_pc", K_PC, 0, 3);
    push("p1_carry", K_CARRY, 0, 0);  push("p1_abort", K_ABORT, 0, 0);
    push("p1_r1", K_REG, 1, 8);       push("p1_r2", K_REG, 2, 3);
    drain();
    press(1'b1);
    push("clr_state", K_STATE, 0, 0); push("clr_count", K_COUNT, 0, 0);
    drain();

    // Carry and borrow, with registers persisting across cleared programs
    enter(5, 0, 0, 200); enter(5, 1, 0, 100); enter(0, 0, 1, 0);
    run_prog(1'b1);
    push("add_cycles", K_CYC, 0, 6);  push("add_r0", K_REG, 0, 44);
    push("add_carry", K_CARRY, 0, 1); push("add_pc", K_PC, 0, 3);
    drain();
    press(1'b1);
    enter(1, 1, 0, 0);
    run_prog(1'b1);
    push("sub1_r1", K_REG, 1, 56);    push("sub1_carry", K_CARRY, 0, 0);
    drain();
    press(1'b1);
    enter(1, 0, 1, 0);
    run_prog(1'b1);
    push("sub2_r0", K_REG, 0, 244);   push("sub2_carry", K_CARRY, 0, 1);
    drain();
    press(1'b1);

    // Countdown loop: LDI r3,3; ADDI r3,255; JNZ r3,1
    enter(5, 3, 0, 3); enter(6, 3, 0, 255); enter(8, 3, 0, 1);
    run_prog(1'b1);
    push("cd_cycles", K_CYC, 0, 14);  push("cd_r3", K_REG, 3, 0);
    push("cd_pc", K_PC, 0, 3);        push("cd_carry", K_CARRY, 0, 1);
    drain();
    press(1'b1);

    // Fill memory; the 17th entry must be dropped
    for (int i = 0; i < 15; i++) enter(10, 0, 0, 0);
    enter(5, 7, 0, 8'h5A);
    push("fill_full", K_FULL, 0, 1);  push("fill_count", K_COUNT, 0, 16);
    drain();
    enter(5, 7, 0, 8'hA5);
    push("ovf_count", K_COUNT, 0, 16); push("ovf_state", K_STATE, 0, 0);
    push("ovf_full", K_FULL, 0, 1);
    drain();
    run_prog(1'b1);
    push("ovf_cycles", K_CYC, 0, 32); push("ovf_r7", K_REG, 7, 8'h5A);
    drain();
    press(1'b1);

    // Infinite loop, abort, rerun, clear, ignored run
    enter(5, 1, 0, 1); enter(8, 1, 0, 0);
    run_prog(1'b0);
    repeat (20) @(negedge clock);
    press(1'b1);
    push("ab_state", K_STATE, 0, 6);  push("ab_abort", K_ABORT, 0, 1);
    push("ab_done", K_DONE, 0, 1);
    drain();
    press(1'b0);
    push("rerun_abort", K_ABORT, 0, 0); push("rerun_done", K_DONE, 0, 0);
    drain();
    chk("rerun_running", (state == 3'd4 || state == 3'd5) ? 1 : 0, 1);
    press(1'b1);
    push("ab2_abort", K_ABORT, 0, 1);
    drain();
    press(1'b1);
    push("ab_clr_count", K_COUNT, 0, 0); push("ab_clr_state", K_STATE, 0, 0);
    push("ab_clr_abort", K_ABORT, 0, 0);
    drain();
    press(1'b0);
    push("empty_run_state", K_STATE, 0, 0);
    drain();

    // Reset during EXEC
    enter(5, 1, 0, 1); enter(8, 1, 0, 0);
    run_prog(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (state == 3'd5) seen = 1'b1;
      else @(negedge clock);
    end
    if (!seen) chk("exec_wait_timeout", 0, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    push("mr_state", K_STATE, 0, 0);  push("mr_count", K_COUNT, 0, 0);
    push("mr_pc", K_PC, 0, 0);        push("mr_done", K_DONE, 0, 0);
    push("mr_r1", K_REG, 1, 0);
    drain();

    // Simultaneous set and run in ENTER_OP with a stored program: set wins
    enter(5, 0, 0, 1);
    press_both();
    push("both_state", K_STATE, 0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
